// File: rtl/manchester_rx_deframer.sv
// Manchester receive deframer.
// Aligns to the half-bit phase of the line, decodes bit pairs, hunts for the
// sync word and deserialises W data bits into a parallel word.
//
// Ports:
//   clk       system clock, one line half-bit per cycle
//   rst       synchronous reset, active-high
//   Din       Manchester line input
//   Dout      last received data word, MSB = first bit received
//   Done      one-cycle strobe, Dout updated this cycle
//   lock      high while in SYNC or DATA
//   code_err  one-cycle strobe, invalid pair while locked
//   err_cnt   saturating count of code_err pulses (only with RX_ERR_CNT_EN)
//
// Optional feature macro: RX_ERR_CNT_EN (adds err_cnt).
module manchester_rx_deframer #(
    parameter int unsigned           W            = 32,
    parameter int unsigned           SYNC_W       = 8,
    parameter logic [SYNC_W-1:0]     SYNC_PATTERN = 8'hD5,
    parameter int unsigned           LOCK_CNT     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Din,
    output logic [W-1:0] Dout,
    output logic         Done,
    output logic         lock,
`ifdef RX_ERR_CNT_EN
    output logic [15:0]  err_cnt,
`endif
    output logic         code_err
);

    localparam int unsigned BCW = $clog2(W);
    localparam int unsigned VCW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              phase, phase_nxt;
    logic              first_half;
    logic [VCW-1:0]    valid_cnt, valid_nxt;
    logic [SYNC_W-1:0] sync_sr, sync_nxt;
    logic [W-2:0]      data_sr, data_nxt;
    logic [BCW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [W-1:0]      dout_nxt;
    logic              done_nxt;
    logic              err_nxt;

    logic              pair_valid;
    logic              pair_bit;
    logic [SYNC_W-1:0] sync_shift;
    logic [W-1:0]      word_full;

    // Pair decode: the first half carries the bit, halves must differ.
    assign pair_valid = first_half ^ Din;
    assign pair_bit   = first_half;
    assign sync_shift = {sync_sr[SYNC_W-2:0], pair_bit};
    assign word_full  = {data_sr, pair_bit};

    // Next-state and output logic.
    always_comb begin
        state_nxt   = state;
        phase_nxt   = ~phase;
        valid_nxt   = valid_cnt;
        sync_nxt    = sync_sr;
        data_nxt    = data_sr;
        bit_cnt_nxt = bit_cnt;
        dout_nxt    = Dout;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;

        if (phase) begin
            unique case (state)
                HUNT: begin
                    if (pair_valid) begin
                        if (valid_cnt >= VCW'(LOCK_CNT - 1)) begin
                            valid_nxt = VCW'(LOCK_CNT);
                            state_nxt = SYNC;
                            sync_nxt  = '0;
                        end else begin
                            valid_nxt = valid_cnt + VCW'(1);
                        end
                    end else begin
                        // Slip: hold phase so the next pair starts one sample later.
                        valid_nxt = '0;
                        phase_nxt = 1'b1;
                    end
                end
                SYNC: begin
                    if (!pair_valid) begin
                        err_nxt   = 1'b1;
                        state_nxt = HUNT;
                        valid_nxt = '0;
                    end else begin
                        sync_nxt = sync_shift;
                        if (sync_shift == SYNC_PATTERN) begin
                            state_nxt   = DATA;
                            bit_cnt_nxt = '0;
                        end
                    end
                end
                DATA: begin
                    if (!pair_valid) begin
                        err_nxt     = 1'b1;
                        state_nxt   = HUNT;
                        valid_nxt   = '0;
                        bit_cnt_nxt = '0;
                    end else begin
                        data_nxt = word_full[W-2:0];
                        if (bit_cnt == BCW'(W - 1)) begin
                            dout_nxt    = word_full;
                            done_nxt    = 1'b1;
                            state_nxt   = SYNC;
                            sync_nxt    = '0;
                            bit_cnt_nxt = '0;
                        end else begin
                            bit_cnt_nxt = bit_cnt + BCW'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    valid_nxt = '0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            phase      <= 1'b0;
            first_half <= 1'b0;
            valid_cnt  <= '0;
            sync_sr    <= '0;
            data_sr    <= '0;
            bit_cnt    <= '0;
            Dout       <= '0;
            Done       <= 1'b0;
            lock       <= 1'b0;
            code_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            first_half <= Din;
            valid_cnt  <= valid_nxt;
            sync_sr    <= sync_nxt;
            data_sr    <= data_nxt;
            bit_cnt    <= bit_cnt_nxt;
            Dout       <= dout_nxt;
            Done       <= done_nxt;
            lock       <= (state_nxt != HUNT);
            code_err   <= err_nxt;
        end
    end

`ifdef RX_ERR_CNT_EN
    // Saturating code error counter, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_nxt && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_manchester_rx_deframer.sv
// Randomised and directed bench for manchester_rx_deframer with a
// behavioural reference model of the receive path.
module tb_manchester_rx_deframer;

    localparam int unsigned W        = 32;
    localparam int unsigned SYNC_W   = 8;
    localparam int unsigned LOCK_CNT = 4;
    localparam logic [7:0]  SYNC_PAT = 8'hD5;

    logic          clk;
    logic          rst;
    logic          Din;
    logic [W-1:0]  Dout;
    logic          Done;
    logic          lock;
    logic          code_err;
`ifdef RX_ERR_CNT_EN
    logic [15:0]   err_cnt;
`endif

    manchester_rx_deframer #(
        .W(W), .SYNC_W(SYNC_W), .SYNC_PATTERN(SYNC_PAT), .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .Din(Din),
        .Dout(Dout),
        .Done(Done),
        .lock(lock),
`ifdef RX_ERR_CNT_EN
        .err_cnt(err_cnt),
`endif
        .code_err(code_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 = hunting, 1 = looking for sync, 2 = collecting data.
    int          m_mode;
    bit          m_second;
    bit          m_prev;
    int          m_valid;
    int unsigned m_sync;
    bit          m_bits[$];
    bit [31:0]   m_dout;
    bit          m_done;
    bit          m_err;
    bit          m_lock;
    int          m_errcnt;

    function automatic void model_reset();
        m_mode = 0; m_second = 0; m_prev = 0; m_valid = 0; m_sync = 0;
        m_bits.delete();
        m_dout = 0; m_done = 0; m_err = 0; m_lock = 0; m_errcnt = 0;
    endfunction

    function automatic void model_step(input bit b);
        bit ok;
        bit dbit;
        bit [31:0] w;
        m_done = 0;
        m_err  = 0;
        if (!m_second) begin
            m_second = 1;
        end else begin
            ok   = (m_prev != b);
            dbit = m_prev;
            m_second = 0;
            if (m_mode == 0) begin
                if (ok) begin
                    m_valid = (m_valid + 1 > int'(LOCK_CNT)) ? int'(LOCK_CNT) : m_valid + 1;
                    if (m_valid == int'(LOCK_CNT)) begin
                        m_mode = 1;
                        m_sync = 0;
                    end
                end else begin
                    m_valid  = 0;
                    m_second = 1;
                end
            end else if (!ok) begin
                m_err   = 1;
                m_mode  = 0;
                m_valid = 0;
                if (m_errcnt < 65535) m_errcnt++;
            end else if (m_mode == 1) begin
                m_sync = ((m_sync << 1) | dbit) & ((1 << SYNC_W) - 1);
                if (m_sync == SYNC_PAT) begin
                    m_mode = 2;
                    m_bits.delete();
                end
            end else begin
                m_bits.push_back(dbit);
                if (m_bits.size() == W) begin
                    w = 0;
                    foreach (m_bits[i]) w = (w << 1) | 32'(m_bits[i]);
                    m_dout = w;
                    m_done = 1;
                    m_mode = 1;
                    m_sync = 0;
                end
            end
        end
        m_prev = b;
        m_lock = (m_mode != 0);
    endfunction

    int done_seen;
    int err_seen;
    bit lock_dropped;

    task automatic compare_all();
        check("dout", Dout, m_dout);
        check("done", 32'(Done), 32'(m_done));
        check("lock", 32'(lock), 32'(m_lock));
        check("code_err", 32'(code_err), 32'(m_err));
`ifdef RX_ERR_CNT_EN
        check("err_cnt", 32'(err_cnt), 32'(m_errcnt));
`endif
        if (Done) done_seen++;
        if (code_err) err_seen++;
        if (!lock) lock_dropped = 1;
    endtask

    task automatic send_half(input bit b);
        Din = b;
        model_step(b);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic send_bit(input bit b);
        send_half(b);
        send_half(~b);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        logic [31:0] t;
        t = v;
        for (int i = n - 1; i >= 0; i--) send_bit(t[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        Din = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        compare_all();
        check("rst_dout", Dout, 32'h0);
        check("rst_lock", 32'(lock), 32'h0);
    endtask

    task automatic preamble_sync();
        for (int i = 0; i < int'(LOCK_CNT); i++) send_bit(1'b0);
        send_bits(32'(SYNC_PAT), 8);
    endtask

    initial begin
        int base;
        logic [31:0] word;
        rst = 1'b1;
        Din = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all();

        // 1: basic frame
        do_reset();
        done_seen = 0; err_seen = 0;
        preamble_sync();
        check("t1_lock", 32'(lock), 32'h1);
        send_bits(32'hDEADBEEF, 32);
        check("t1_done_cnt", 32'(done_seen), 32'd1);
        check("t1_dout", Dout, 32'hDEADBEEF);
        check("t1_err_cnt", 32'(err_seen), 32'd0);

        // 2: odd half-bit offset forces a slip
        do_reset();
        done_seen = 0;
        send_half(1'b0);
        preamble_sync();
        send_bits(32'hDEADBEEF, 32);
        check("t2_done_cnt", 32'(done_seen), 32'd1);
        check("t2_dout", Dout, 32'hDEADBEEF);

        // 3: back-to-back frames
        done_seen = 0; lock_dropped = 0;
        send_bits(32'(SYNC_PAT), 8);
        send_bits(32'h00000001, 32);
        check("t3_dout1", Dout, 32'h00000001);
        send_bits(32'(SYNC_PAT), 8);
        send_bits(32'h80000000, 32);
        check("t3_done_cnt", 32'(done_seen), 32'd2);
        check("t3_dout2", Dout, 32'h80000000);
        check("t3_lock_held", 32'(lock_dropped), 32'd0);

        // 4: invalid pair at data bit 10
        done_seen = 0; err_seen = 0;
        send_bits(32'(SYNC_PAT), 8);
        send_bits(32'h3FF, 10);
        send_half(1'b1);
        send_half(1'b1);
        check("t4_code_err", 32'(code_err), 32'd1);
        check("t4_lock", 32'(lock), 32'd0);
        check("t4_dout", Dout, 32'h80000000);
        send_half(1'b0);
        check("t4_err_pulse", 32'(err_seen), 32'd1);
        check("t4_no_done", 32'(done_seen), 32'd0);
`ifdef RX_ERR_CNT_EN
        check("t4_err_cnt", 32'(err_cnt), 32'd1);
`endif

        // 5: reset during data bit 20
        do_reset();
        preamble_sync();
        send_bits(32'hCAFEF00D, 32);
        send_bits(32'(SYNC_PAT), 8);
        send_bits(32'h55555, 20);
        do_reset();
        check("t5_done", 32'(Done), 32'd0);
        done_seen = 0;
        preamble_sync();
        send_bits(32'hA5C3_0F96, 32);
        check("t5_done_cnt", 32'(done_seen), 32'd1);
        check("t5_dout", Dout, 32'hA5C30F96);

        // 6: near-miss sync word is ignored
        do_reset();
        done_seen = 0;
        for (int i = 0; i < int'(LOCK_CNT); i++) send_bit(1'b0);
        send_bits(32'hD4, 8);
        send_bits(32'(SYNC_PAT), 8);
        send_bits(32'h12345678, 32);
        check("t6_done_cnt", 32'(done_seen), 32'd1);
        check("t6_dout", Dout, 32'h12345678);

        // Randomised frames with noise and injected errors
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 1) == 0) do_reset();
            base = $urandom_range(0, 9);
            for (int i = 0; i < base; i++) send_half(1'($urandom_range(0, 1)));
            for (int i = 0; i < int'($urandom_range(LOCK_CNT, LOCK_CNT + 3)); i++)
                send_bit(1'($urandom_range(0, 1)));
            send_bits(32'(SYNC_PAT), 8);
            word = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                base = $urandom_range(0, 31);
                for (int i = 31; i > 31 - base; i--) send_bit(word[i]);
                send_half(word[0]);
                send_half(word[0]);
            end else begin
                send_bits(word, 32);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
